// File: rtl/tia_clk_sequencer.sv
// TIA front-end measurement sequencer: walks enabled channels, clocks each TIA and requests ADC conversions.
// Optional ADC watchdog is compiled in with `define TIA_SEQ_ADC_TIMEOUT_EN.
module tia_clk_sequencer #(
    parameter int NUM_CH = 8,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8,
    parameter int TMO_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [NUM_CH-1:0] cfg_ch_mask,
    input  logic [DIV_W-1:0]  cfg_half_period,
    input  logic [DIV_W-1:0]  cfg_settle,
    input  logic [CNT_W-1:0]  cfg_num_samples,
    input  logic              adc_done,
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
    input  logic [TMO_W-1:0]  cfg_adc_timeout,
`endif
    output logic              tia_clk,
    output logic [CH_W-1:0]   ch_sel,
    output logic              ch_en,
    output logic              adc_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  sample_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_CLK_HI, S_CLK_LO, S_CONVERT, S_NEXT, S_DONE
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] rem_mask;
    logic [DIV_W-1:0]  half_cfg;
    logic [DIV_W-1:0]  settle_cfg;
    logic [CNT_W-1:0]  num_cfg;
    logic [DIV_W-1:0]  cnt;

    logic [DIV_W-1:0]  half_eff;
    logic [CNT_W:0]    num_eff;
    logic [CNT_W:0]    idx_inc;
    logic              last_sample;
    logic [NUM_CH-1:0] rem_cleared;
    logic              wdog_fire;

    function automatic logic [CH_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) idx = CH_W'(i);
        return idx;
    endfunction

    // Zero-valued period/count fields behave as 1; one extra bit keeps the compare from wrapping.
    assign half_eff    = (half_cfg == '0) ? DIV_W'(1) : half_cfg;
    assign num_eff     = (num_cfg == '0) ? (CNT_W+1)'(1) : {1'b0, num_cfg};
    assign idx_inc     = {1'b0, sample_idx} + 1'b1;
    assign last_sample = (idx_inc >= num_eff);
    assign rem_cleared = rem_mask & ~(NUM_CH'(1) << ch_sel);

`ifdef TIA_SEQ_ADC_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cfg;
    logic [TMO_W-1:0] wdog;
    assign wdog_fire = (tmo_cfg != '0) && (wdog == TMO_W'(1));
`else
    assign wdog_fire = (TMO_W < 0);
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= S_IDLE;
            tia_clk    <= 1'b0;
            ch_sel     <= '0;
            ch_en      <= 1'b0;
            adc_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sample_idx <= '0;
            rem_mask   <= '0;
            half_cfg   <= '0;
            settle_cfg <= '0;
            num_cfg    <= '0;
            cnt        <= '0;
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
            tmo_cfg    <= '0;
            wdog       <= '0;
`endif
        end else begin
            adc_start <= 1'b0;
            done      <= 1'b0;
            if (busy && cfg_abort) begin
                state <= S_DONE; tia_clk <= 1'b0; ch_en <= 1'b0; busy <= 1'b0; done <= 1'b1; err <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start && !cfg_abort) begin
                            rem_mask   <= cfg_ch_mask;
                            half_cfg   <= cfg_half_period;
                            settle_cfg <= cfg_settle;
                            num_cfg    <= cfg_num_samples;
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
                            tmo_cfg    <= cfg_adc_timeout;
`endif
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            state      <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        if (rem_mask == '0) begin
                            state <= S_DONE; tia_clk <= 1'b0; ch_en <= 1'b0; busy <= 1'b0; done <= 1'b1; err <= 1'b1;
                        end else begin
                            ch_sel     <= lowest_bit(rem_mask);
                            ch_en      <= 1'b1;
                            sample_idx <= '0;
                            if (settle_cfg == '0) begin
                                state <= S_CLK_HI; tia_clk <= 1'b1; cnt <= half_eff - 1'b1;
                            end else begin
                                state <= S_SETTLE; cnt <= settle_cfg - 1'b1;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == '0) begin
                            state <= S_CLK_HI; tia_clk <= 1'b1; cnt <= half_eff - 1'b1;
                        end else cnt <= cnt - 1'b1;
                    end
                    S_CLK_HI: begin
                        if (cnt == '0) begin
                            state <= S_CLK_LO; tia_clk <= 1'b0; cnt <= half_eff - 1'b1;
                        end else cnt <= cnt - 1'b1;
                    end
                    S_CLK_LO: begin
                        if (cnt == '0) begin
                            state <= S_CONVERT; adc_start <= 1'b1;
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
                            wdog <= tmo_cfg;
`endif
                        end else cnt <= cnt - 1'b1;
                    end
                    S_CONVERT: begin
                        if (adc_done) state <= S_NEXT;
                        else if (wdog_fire) begin
                            state <= S_DONE; tia_clk <= 1'b0; ch_en <= 1'b0; busy <= 1'b0; done <= 1'b1; err <= 1'b1;
                        end
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
                        wdog <= wdog - 1'b1;
`endif
                    end
                    S_NEXT: begin
                        if (!last_sample) begin
                            sample_idx <= sample_idx + 1'b1;
                            state <= S_CLK_HI; tia_clk <= 1'b1; cnt <= half_eff - 1'b1;
                        end else begin
                            rem_mask <= rem_cleared;
                            if (rem_cleared != '0) state <= S_SELECT;
                            else begin
                                state <= S_DONE; tia_clk <= 1'b0; ch_en <= 1'b0; busy <= 1'b0; done <= 1'b1;
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tia_clk_sequencer.sv
// Randomized scoreboard bench for tia_clk_sequencer: a cycle-level event model predicts every
// tia_clk rise, adc_start and done pulse; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_tia_clk_sequencer;
    localparam int NUM_CH = 8;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 8;
    localparam int TMO_W  = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [7:0]  cfg_ch_mask = '0;
    logic [15:0] cfg_half_period = '0;
    logic [15:0] cfg_settle = '0;
    logic [7:0]  cfg_num_samples = '0;
    logic        adc_resp = 1'b0;
    logic        adc_poke = 1'b0;
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
    logic [15:0] cfg_adc_timeout = '0;
`endif
    logic        tia_clk, ch_en, adc_start, busy, done, err;
    logic [2:0]  ch_sel;
    logic [7:0]  sample_idx;

    tia_clk_sequencer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_ch_mask(cfg_ch_mask), .cfg_half_period(cfg_half_period), .cfg_settle(cfg_settle),
        .cfg_num_samples(cfg_num_samples), .adc_done(adc_resp | adc_poke),
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
        .cfg_adc_timeout(cfg_adc_timeout),
`endif
        .tia_clk(tia_clk), .ch_sel(ch_sel), .ch_en(ch_en), .adc_start(adc_start),
        .busy(busy), .done(done), .err(err), .sample_idx(sample_idx)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct { int cyc; int ch; int idx; } conv_t;
    typedef struct { int cyc; bit e; } done_t;
    conv_t conv_q[$];
    done_t done_q[$];
    int    rise_q[$];

    int  total = 0, bad = 0;
    int  exp_h = 1;
    bit  bchk = 0;
    int  run_t0 = 0, run_done = 0;
    int  first_conv = -1;
    int  resp_d = 1;
    bit  resp_en = 1'b1;
    logic prev_clk = 1'b0;
    int  hi_len = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference model: cycle numbers of every observable event, from the timing rules alone.
    task automatic plan(input logic [7:0] m, input int h, input int s, input int n, input int d,
                        input int t0, input int abort_k, input bit stall, input int tmo,
                        output int done_cyc, output int abort_cyc);
        int H, N, sel, rise, a, nx, k;
        bit stop, e;
        H = (h == 0) ? 1 : h;
        N = (n == 0) ? 1 : n;
        exp_h = H;
        abort_cyc = -1; done_cyc = -1; first_conv = -1;
        k = 0; stop = 0; e = 0;
        sel = t0 + 1; nx = sel;
        if (m == 0) begin
            done_cyc = t0 + 2;
            done_q.push_back('{t0 + 2, 1'b1});
            return;
        end
        for (int ch = 0; ch < NUM_CH && !stop; ch++) begin
            if (m[ch]) begin
                rise = sel + 1 + s;
                for (int i = 0; i < N && !stop; i++) begin
                    rise_q.push_back(rise);
                    k++;
                    if (k == abort_k) begin
                        abort_cyc = rise; stop = 1;
                    end else begin
                        a = rise + 2 * H;
                        conv_q.push_back('{a, ch, i});
                        if (first_conv < 0) first_conv = a;
                        if (stall) stop = 1;
                        nx = a + d + 1;
                        rise = nx + 1;
                    end
                end
                sel = nx + 1;
            end
        end
        if (abort_cyc >= 0) begin done_cyc = abort_cyc + 1; e = 1; end
        else if (stall) begin done_cyc = (tmo > 0) ? first_conv + tmo : -1; e = 1; end
        else done_cyc = nx + 1;
        if (done_cyc >= 0) done_q.push_back('{done_cyc, e});
    endtask

    task automatic run(input logic [7:0] m, input int h, input int s, input int n, input int d,
                       input int abort_k, input bit stall, input int tmo, input bit poke);
        int t0, dc, ac;
        @(negedge ACLK);
        cfg_ch_mask = m; cfg_half_period = 16'(h); cfg_settle = 16'(s); cfg_num_samples = 8'(n);
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
        cfg_adc_timeout = 16'(tmo);
`endif
        resp_d = d; resp_en = !stall; cfg_start = 1'b1;
        t0 = cyc;
        plan(m, h, s, n, d, t0, abort_k, stall, tmo, dc, ac);
        run_t0 = t0; run_done = (dc < 0) ? 32'h3fff_ffff : dc; bchk = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
        cfg_ch_mask = 8'($urandom); cfg_half_period = 16'($urandom); cfg_settle = 16'($urandom);
        cfg_num_samples = 8'($urandom);
`ifdef TIA_SEQ_ADC_TIMEOUT_EN
        cfg_adc_timeout = 16'($urandom_range(1, 3));
`endif
        if (poke) begin
            repeat (2) @(negedge ACLK);
            cfg_ch_mask = 8'hFF; cfg_start = 1'b1;
            @(negedge ACLK);
            cfg_start = 1'b0;
        end
        if (ac >= 0) begin
            while (cyc < ac) @(negedge ACLK);
            cfg_abort = 1'b1;
            @(negedge ACLK);
            cfg_abort = 1'b0;
        end
        if (dc >= 0) begin
            while (cyc < dc + 1) @(negedge ACLK);
            check("missing_adc_start", conv_q.size(), 0);
            check("missing_rise", rise_q.size(), 0);
            check("missing_done", done_q.size(), 0);
        end
    endtask

    // ADC model: answers each request after resp_d cycles with a one-cycle done pulse.
    always begin
        @(negedge ACLK);
        if (adc_start === 1'b1 && resp_en) begin
            for (int i = 0; i < resp_d; i++) @(negedge ACLK);
            adc_resp = 1'b1;
            @(negedge ACLK);
            adc_resp = 1'b0;
        end
    end

    always @(negedge ACLK) begin
        conv_t c;
        done_t dd;
        if (bchk) check("busy", busy, (cyc > run_t0 && cyc < run_done));
        if (tia_clk === 1'b1 && prev_clk === 1'b0) begin
            if (rise_q.size() == 0) check("rise_queue", rise_q.size(), 1);
            else check("rise_cycle", cyc, rise_q.pop_front());
        end
        if (tia_clk === 1'b0 && prev_clk === 1'b1 && done !== 1'b1) check("clk_high_len", hi_len, exp_h);
        hi_len = (tia_clk === 1'b1) ? hi_len + 1 : 0;
        prev_clk = tia_clk;
        if (adc_start === 1'b1) begin
            if (conv_q.size() == 0) check("adc_start_queue", conv_q.size(), 1);
            else begin
                c = conv_q.pop_front();
                check("adc_start_cycle", cyc, c.cyc);
                check("conv_ch_sel", ch_sel, c.ch);
                check("conv_sample_idx", sample_idx, c.idx);
                check("conv_ch_en", ch_en, 1);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) check("done_queue", done_q.size(), 1);
            else begin
                dd = done_q.pop_front();
                check("done_cycle", cyc, dd.cyc);
                check("done_err", err, dd.e);
                check("done_busy", busy, 0);
                check("done_tia_clk", tia_clk, 0);
                check("done_ch_en", ch_en, 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tia_clk"}, tia_clk, 0);
        check({tag, "_ch_sel"}, ch_sel, 0);
        check({tag, "_ch_en"}, ch_en, 0);
        check({tag, "_adc_start"}, adc_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_sample_idx"}, sample_idx, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        ARESET = 1'b0;

        // adc_done while idle must not do anything
        @(negedge ACLK); adc_poke = 1'b1;
        @(negedge ACLK); adc_poke = 1'b0;
        repeat (3) @(negedge ACLK);
        check("idle_busy", busy, 0);
        check("idle_tia_clk", tia_clk, 0);

        run(8'b0000_0101, 2, 3, 2, 1, 0, 1'b0, 0, 1'b1);
        check("basic_err", err, 0);

        run(8'h80, 0, 0, 0, $urandom_range(0, 3), 0, 1'b0, 0, 1'b0);
        check("zero_fields_err", err, 0);

        run(8'h00, 1, 1, 1, 1, 0, 1'b0, 0, 1'b0);
        check("empty_mask_err", err, 1);

        run(8'hFF, 1, 1, 1, 1, 2, 1'b0, 0, 1'b0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 1);
        run(8'h01, 1, 0, 1, 1, 0, 1'b0, 0, 1'b0);
        check("after_abort_err", err, 0);

        run(8'h02, 1, 0, 255, 0, 0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run(m, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), 0, 1'b0, 0, 1'b0);
            check("random_err", err, (m == 0));
        end

        // reset while waiting in CONVERT
        run(8'h01, 1, 0, 1, 0, 0, 1'b1, 0, 1'b0);
        while (cyc < first_conv + 1) @(negedge ACLK);
        bchk = 1'b0; ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check_all_zero("midrun_reset");
        repeat (3) @(negedge ACLK);
        check("midrun_reset_conv_q", conv_q.size(), 0);
        check("midrun_reset_busy", busy, 0);

`ifdef TIA_SEQ_ADC_TIMEOUT_EN
        run(8'h01, 1, 0, 1, 0, 0, 1'b1, 10, 1'b0);
        check("timeout_err", err, 1);
`else
        run(8'h01, 1, 0, 1, 0, 0, 1'b1, 0, 1'b0);
        repeat (1000) @(negedge ACLK);
        check("stall_busy", busy, 1);
        cfg_abort = 1'b1;
        done_q.push_back('{cyc + 1, 1'b1});
        run_done = cyc + 1;
        @(negedge ACLK);
        cfg_abort = 1'b0;
        repeat (2) @(negedge ACLK);
        check("stall_abort_done_q", done_q.size(), 0);
        check("stall_abort_err", err, 1);
`endif

        repeat (3) @(negedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
